// File: rtl/spmv_mac.sv
// -----------------------------------------------------------------------------
// spmv_mac -- multiply-accumulate stage of the sparse matrix-vector pipeline.
//
// Each lane pops one vector value and one matrix nonzero (plus row-end flag)
// from its pair of standard-mode FIFOs, multiplies them and accumulates the
// product into a per-lane row sum. A finished row sum parks in a per-lane
// result slot until a round-robin arbiter moves it into the registered output.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   vec_val       vector values, lane f at [f*VAL_W +: VAL_W]
//   vec_empty     vector FIFO empty flags
//   vec_read      vector FIFO read strobes (combinational, equal to mat_read)
//   mat_val       matrix nonzero values, lane f at [f*VAL_W +: VAL_W]
//   mat_last      per-lane row-end flag accompanying mat_val
//   mat_empty     matrix FIFO empty flags
//   mat_read      matrix FIFO read strobes
//   out_data      row sum
//   out_lane      lane that produced out_data
//   out_row       per-lane row index of out_data
//   out_valid     output valid
//   out_ready     downstream accept
//
// Build option: define SPMV_MAC_SAT_EN to make accumulation saturate at
// 2^ACC_W-1 instead of wrapping modulo 2^ACC_W.
// -----------------------------------------------------------------------------
module spmv_mac #(
  parameter  int CHANNEL_NUM = 4,
  parameter  int VAL_W       = 8,
  parameter  int ACC_W       = 24,
  parameter  int ROW_W       = 10,
  localparam int LANE_W      = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNEL_NUM*VAL_W-1:0] vec_val,
  input  logic [CHANNEL_NUM-1:0]       vec_empty,
  output logic [CHANNEL_NUM-1:0]       vec_read,
  input  logic [CHANNEL_NUM*VAL_W-1:0] mat_val,
  input  logic [CHANNEL_NUM-1:0]       mat_last,
  input  logic [CHANNEL_NUM-1:0]       mat_empty,
  output logic [CHANNEL_NUM-1:0]       mat_read,
  output logic [ACC_W-1:0]             out_data,
  output logic [LANE_W-1:0]            out_lane,
  output logic [ROW_W-1:0]             out_row,
  output logic                         out_valid,
  input  logic                         out_ready
);

  logic [CHANNEL_NUM-1:0] accept_s;
  logic [CHANNEL_NUM-1:0] inflight_r;
  logic [CHANNEL_NUM-1:0] inflight_last_r;
  logic [CHANNEL_NUM-1:0] res_valid_r;
  logic [ACC_W-1:0]       acc_r     [CHANNEL_NUM];
  logic [ACC_W-1:0]       res_r     [CHANNEL_NUM];
  logic [ROW_W-1:0]       row_cnt_r [CHANNEL_NUM];
  logic [2*VAL_W-1:0]     prod_s    [CHANNEL_NUM];
  logic [ACC_W-1:0]       sum_s     [CHANNEL_NUM];
`ifdef SPMV_MAC_SAT_EN
  logic [ACC_W:0]         wide_s    [CHANNEL_NUM];
`endif

  logic [LANE_W-1:0]      last_grant_r;
  logic                   load_s;
  logic                   grant_valid_s;
  logic [LANE_W-1:0]      grant_lane_s;
  logic [CHANNEL_NUM-1:0] grant_onehot_s;

  // A lane pops only when both FIFOs have data and no finished row is parked.
  // The (inflight & mat_last) term also holds the lane while a row-end pair is
  // still in flight: a one-pair row popped in that cycle would otherwise land
  // on the result slot before the arbiter has had a chance to empty it.
  assign accept_s = ~vec_empty & ~mat_empty & ~res_valid_r
                  & ~(inflight_r & inflight_last_r)
                  & ~(inflight_r & mat_last);
  assign vec_read = accept_s;
  assign mat_read = accept_s;

  // Per-lane product of the FIFO outputs and the next accumulator value.
  always_comb begin
    for (int f = 0; f < CHANNEL_NUM; f++) begin
      prod_s[f] = (2*VAL_W)'(vec_val[f*VAL_W +: VAL_W])
                * (2*VAL_W)'(mat_val[f*VAL_W +: VAL_W]);
`ifdef SPMV_MAC_SAT_EN
      wide_s[f] = {1'b0, acc_r[f]} + {1'b0, ACC_W'(prod_s[f])};
      if (wide_s[f][ACC_W]) begin
        sum_s[f] = '1;
      end else begin
        sum_s[f] = wide_s[f][ACC_W-1:0];
      end
`else
      sum_s[f] = acc_r[f] + ACC_W'(prod_s[f]);
`endif
    end
  end

  // Round-robin pick: first lane with a parked result after the last grant.
  always_comb begin : arb_comb
    int unsigned idx_v;
    idx_v         = 0;
    grant_valid_s = 1'b0;
    grant_lane_s  = '0;
    for (int i = 1; i <= CHANNEL_NUM; i++) begin
      idx_v = (int'(last_grant_r) + i) % CHANNEL_NUM;
      if (!grant_valid_s && res_valid_r[idx_v]) begin
        grant_valid_s = 1'b1;
        grant_lane_s  = LANE_W'(idx_v);
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
  end

  assign load_s = ~out_valid | out_ready;

  // Decode the effective grant (only when the output register can load).
  always_comb begin
    for (int f = 0; f < CHANNEL_NUM; f++) begin
      grant_onehot_s[f] = load_s & grant_valid_s & (grant_lane_s == LANE_W'(f));
    end
  end

  // Lane pipeline: in-flight tracking, accumulation, result slot, row counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_r      <= '0;
      inflight_last_r <= '0;
      res_valid_r     <= '0;
      for (int f = 0; f < CHANNEL_NUM; f++) begin
        acc_r[f]     <= '0;
        res_r[f]     <= '0;
        row_cnt_r[f] <= '0;
      end
    end else begin
      for (int f = 0; f < CHANNEL_NUM; f++) begin
        inflight_r[f]      <= accept_s[f];
        inflight_last_r[f] <= inflight_r[f] & mat_last[f];
        if (grant_onehot_s[f]) begin
          res_valid_r[f] <= 1'b0;
          row_cnt_r[f]   <= row_cnt_r[f] + ROW_W'(1);
        end
        if (inflight_r[f]) begin
          if (mat_last[f]) begin
            res_r[f]       <= sum_s[f];
            res_valid_r[f] <= 1'b1;
            acc_r[f]       <= '0;
          end else begin
            acc_r[f] <= sum_s[f];
          end
        end
      end
    end
  end

  // Output register and arbiter pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_lane     <= '0;
      out_row      <= '0;
      last_grant_r <= LANE_W'(CHANNEL_NUM - 1);
    end else if (load_s) begin
      if (grant_valid_s) begin
        out_valid    <= 1'b1;
        out_data     <= res_r[grant_lane_s];
        out_lane     <= grant_lane_s;
        out_row      <= row_cnt_r[grant_lane_s];
        last_grant_r <= grant_lane_s;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spmv_mac.sv
// -----------------------------------------------------------------------------
// tb_spmv_mac -- self-checking bench for spmv_mac.
// FIFOs are modelled as per-lane queues; expected row results are computed at
// push time with plain arithmetic and matched per lane when outputs are taken.
// -----------------------------------------------------------------------------
module tb_spmv_mac;
  localparam int CH = 4;
  localparam int VW = 8;
  localparam int AW = 24;
  localparam int RW = 10;
  localparam int LW = 2;
  localparam longint ACC_MAX = 64'd16777215;
  localparam longint ACC_MOD = 64'd16777216;
`ifdef SPMV_MAC_SAT_EN
  localparam longint OVF_EXP = 64'd16777215;
`else
  localparam longint OVF_EXP = 64'd2730284;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [CH*VW-1:0] vec_val, mat_val;
  logic [CH-1:0] vec_empty, vec_read, mat_last, mat_empty, mat_read;
  logic [AW-1:0] out_data;
  logic [LW-1:0] out_lane;
  logic [RW-1:0] out_row;
  logic out_valid, out_ready;

  spmv_mac #(.CHANNEL_NUM(CH), .VAL_W(VW), .ACC_W(AW), .ROW_W(RW)) dut (
    .clk(clk), .rst(rst),
    .vec_val(vec_val), .vec_empty(vec_empty), .vec_read(vec_read),
    .mat_val(mat_val), .mat_last(mat_last), .mat_empty(mat_empty), .mat_read(mat_read),
    .out_data(out_data), .out_lane(out_lane), .out_row(out_row),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct { int m; bit last; } mpair_t;
  typedef struct { longint data; int row; } exp_t;
  typedef struct { int lane; longint data; int row; int cyc; } log_t;

  int     vq [CH][$];
  mpair_t mq [CH][$];
  exp_t   exp_q [CH][$];
  log_t   log_q [$];
  longint acc_m [CH];
  int     row_m [CH];
  int     pops [CH];
  int     last_rd_cyc [CH];
  int     cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: row sum computed from the spec's arithmetic at push time.
  task automatic model_pair(input int f, input int v, input int m, input bit last);
    exp_t e;
    acc_m[f] = acc_m[f] + longint'(v) * longint'(m);
`ifdef SPMV_MAC_SAT_EN
    if (acc_m[f] > ACC_MAX) acc_m[f] = ACC_MAX;
`else
    acc_m[f] = acc_m[f] % ACC_MOD;
`endif
    if (last) begin
      e.data = acc_m[f];
      e.row  = row_m[f];
      exp_q[f].push_back(e);
      row_m[f] = (row_m[f] + 1) % 1024;
      acc_m[f] = 0;
    end
  endtask

  task automatic push_pair(input int f, input int v, input int m, input bit last);
    mpair_t mp;
    mp.m = m;
    mp.last = last;
    vq[f].push_back(v);
    mq[f].push_back(mp);
    model_pair(f, v, m, last);
  endtask

  function automatic int pending();
    int n = 0;
    for (int f = 0; f < CH; f++) n += exp_q[f].size() + vq[f].size() + mq[f].size();
    return n;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    log_q.delete();
    for (int f = 0; f < CH; f++) begin
      exp_q[f].delete();
      acc_m[f] = 0;
      row_m[f] = 0;
      pops[f] = 0;
      last_rd_cyc[f] = -100;
    end
    tick(2);
    rst = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while ((pending() != 0 || out_valid) && k < budget) begin
      tick(1);
      k++;
    end
    chk({name, "_drain_left"}, longint'(pending()), 64'd0);
  endtask

  // FIFO model: standard mode, dout updates in the cycle after a read strobe.
  initial begin
    logic [CH-1:0] rd_v;
    int rc;
    mpair_t mp;
    vec_val = '0; mat_val = '0; mat_last = '0;
    vec_empty = '1; mat_empty = '1;
    forever begin
      @(negedge clk);
      rd_v = vec_read;
      rc = cyc;
      @(posedge clk);
      #1;
      for (int f = 0; f < CH; f++) begin
        if (rd_v[f] === 1'b1 && vq[f].size() > 0 && mq[f].size() > 0) begin
          vec_val[f*VW +: VW] = VW'(vq[f].pop_front());
          mp = mq[f].pop_front();
          mat_val[f*VW +: VW] = VW'(mp.m);
          mat_last[f] = mp.last;
          pops[f]++;
          if (mp.last) last_rd_cyc[f] = rc;
        end
      end
      for (int f = 0; f < CH; f++) begin
        vec_empty[f] = (vq[f].size() == 0);
        mat_empty[f] = (mq[f].size() == 0);
      end
    end
  end

  // Compare process: every cycle, check strobes, output hold and taken results.
  initial begin
    bit hold_v = 1'b0;
    logic [AW-1:0] hd;
    logic [LW-1:0] hl;
    logic [RW-1:0] hr;
    exp_t e;
    log_t lg;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        hold_v = 1'b0;
      end else begin
        chk("rd_pair", longint'(vec_read), longint'(mat_read));
        chk("rd_when_empty", longint'(vec_read & (vec_empty | mat_empty)), 64'd0);
        if (hold_v) begin
          chk("hold_valid", longint'(out_valid), 64'd1);
          chk("hold_data", longint'(out_data), longint'(hd));
          chk("hold_lane", longint'(out_lane), longint'(hl));
          chk("hold_row", longint'(out_row), longint'(hr));
        end
        hold_v = 1'b0;
        if (out_valid === 1'b1) begin
          if (out_ready) begin
            chk("unexpected_result", longint'(exp_q[out_lane].size() > 0), 64'd1);
            if (exp_q[out_lane].size() > 0) begin
              e = exp_q[out_lane].pop_front();
              chk("model_data", longint'(out_data), e.data);
              chk("model_row", longint'(out_row), longint'(e.row));
            end
            lg.lane = int'(out_lane);
            lg.data = longint'(out_data);
            lg.row  = int'(out_row);
            lg.cyc  = cyc;
            log_q.push_back(lg);
          end else begin
            hold_v = 1'b1;
            hd = out_data;
            hl = out_lane;
            hr = out_row;
          end
        end
      end
    end
  end

  // Watchdog: the run must end on its own.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    for (int f = 0; f < CH; f++) begin
      acc_m[f] = 0; row_m[f] = 0; pops[f] = 0; last_rd_cyc[f] = -100;
    end
    tick(3);
    chk("rst_valid", longint'(out_valid), 64'd0);
    chk("rst_data", longint'(out_data), 64'd0);
    chk("rst_lane", longint'(out_lane), 64'd0);
    chk("rst_row", longint'(out_row), 64'd0);
    chk("rst_read", longint'(vec_read), 64'd0);
    rst = 1'b0;
    tick(1);

    // Single row on lane 0: 2*5 + 3*6 + 4*7 = 56.
    push_pair(0, 2, 5, 1'b0);
    push_pair(0, 3, 6, 1'b0);
    push_pair(0, 4, 7, 1'b1);
    drain("t1", 50);
    chk("t1_count", longint'(log_q.size()), 64'd1);
    if (log_q.size() == 1) begin
      chk("t1_data", log_q[0].data, 64'd56);
      chk("t1_lane", longint'(log_q[0].lane), 64'd0);
      chk("t1_row", longint'(log_q[0].row), 64'd0);
      chk("t1_latency", longint'(log_q[0].cyc - last_rd_cyc[0]), 64'd3);
    end

    // Round robin: four one-pair rows finishing together -> lanes 0..3 in order.
    do_reset();
    for (int f = 0; f < CH; f++) push_pair(f, 1, f + 1, 1'b1);
    drain("t2", 50);
    chk("t2_count", longint'(log_q.size()), 64'd4);
    if (log_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t2_lane", longint'(log_q[i].lane), longint'(i));
        chk("t2_data", log_q[i].data, longint'(i + 1));
        chk("t2_b2b", longint'(log_q[i].cyc - log_q[0].cyc), longint'(i));
      end
    end

    // Backpressure: lane 1 rows of 10 and 20, a third row must stay unread.
    do_reset();
    out_ready = 1'b0;
    push_pair(1, 1, 2, 1'b0);
    push_pair(1, 2, 4, 1'b1);
    push_pair(1, 4, 5, 1'b1);
    push_pair(1, 1, 7, 1'b1);
    tick(14);
    chk("t3_held_valid", longint'(out_valid), 64'd1);
    chk("t3_held_data", longint'(out_data), 64'd10);
    chk("t3_held_lane", longint'(out_lane), 64'd1);
    chk("t3_held_row", longint'(out_row), 64'd0);
    chk("t3_stalled_fifo", longint'(vq[1].size()), 64'd1);
    chk("t3_pops", longint'(pops[1]), 64'd3);
    out_ready = 1'b1;
    drain("t3", 50);
    chk("t3_count", longint'(log_q.size()), 64'd3);
    if (log_q.size() == 3) begin
      chk("t3_data0", log_q[0].data, 64'd10);
      chk("t3_row0", longint'(log_q[0].row), 64'd0);
      chk("t3_data1", log_q[1].data, 64'd20);
      chk("t3_row1", longint'(log_q[1].row), 64'd1);
      chk("t3_b2b", longint'(log_q[1].cyc - log_q[0].cyc), 64'd1);
      chk("t3_data2", log_q[2].data, 64'd7);
    end

    // Empty handling: vector present, matrix absent -> no read, no output.
    do_reset();
    vq[2].push_back(6);
    tick(6);
    chk("t4_no_read", longint'(vec_read[2]), 64'd0);
    chk("t4_no_pop", longint'(pops[2]), 64'd0);
    chk("t4_no_out", longint'(out_valid), 64'd0);
    begin
      mpair_t mp;
      mp.m = 7;
      mp.last = 1'b1;
      mq[2].push_back(mp);
      model_pair(2, 6, 7, 1'b1);
    end
    drain("t4", 50);
    chk("t4_pop", longint'(pops[2]), 64'd1);
    chk("t4_count", longint'(log_q.size()), 64'd1);
    if (log_q.size() == 1) begin
      chk("t4_data", log_q[0].data, 64'd42);
      chk("t4_lane", longint'(log_q[0].lane), 64'd2);
    end

    // Overflow: 300 * 255 * 255 in a single row.
    do_reset();
    for (int i = 0; i < 300; i++) push_pair(0, 255, 255, (i == 299));
    drain("t5", 1000);
    chk("t5_count", longint'(log_q.size()), 64'd1);
    if (log_q.size() == 1) chk("t5_data", log_q[0].data, OVF_EXP);

    // Reset mid-row: partial sum discarded, fresh row starts at row 0.
    do_reset();
    push_pair(0, 5, 5, 1'b0);
    push_pair(0, 6, 6, 1'b0);
    tick(6);
    chk("t6_consumed", longint'(vq[0].size()), 64'd0);
    do_reset();
    push_pair(0, 3, 3, 1'b1);
    drain("t6", 50);
    chk("t6_count", longint'(log_q.size()), 64'd1);
    if (log_q.size() == 1) begin
      chk("t6_data", log_q[0].data, 64'd9);
      chk("t6_row", longint'(log_q[0].row), 64'd0);
    end

    tick(4);
    chk("final_pending", longint'(pending()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
